// File: rtl/div_nrda_fsm.sv
// Sequential unsigned divider, one quotient bit per clock, start/ready handshake. Build option DIV_RESTORING_EN selects restoring.
// Latency: N+1 edges after acceptance (non-restoring, with FIX step) or N edges (restoring).
// Backpressure: none; start is sampled only in IDLE, ignored otherwise, ready pulses one cycle in DONE.
module div_nrda_fsm #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         ready
);

    localparam int CW = $clog2(N + 1);

`ifdef DIV_RESTORING_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
`endif

    state_t        state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N:0]    m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          rdy_q, rdy_d;

    // One iteration step: A takes the MSB of Q; A's old sign bit falls off (mod 2^(N+1)).
    logic [N:0]    a_sh;
    logic [N:0]    a_it;
    logic [N-1:0]  q_it;

    assign a_sh = {a_q[N-1:0], q_q[N-1]};

`ifdef DIV_RESTORING_EN
    logic [N:0] t_it;
    logic       unused_sign;

    assign t_it        = a_sh - m_q;
    assign a_it        = t_it[N] ? a_sh : t_it;
    assign q_it        = {q_q[N-2:0], ~t_it[N]};
    assign unused_sign = a_q[N];
`else
    logic [N:0] a_fix;

    assign a_it  = a_q[N] ? (a_sh + m_q) : (a_sh - m_q);
    assign q_it  = {q_q[N-2:0], ~a_it[N]};
    assign a_fix = a_q[N] ? (a_q + m_q) : a_q;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = dividend;
                    m_d     = {1'b0, divisor};
                    cnt_d   = CW'(N);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_it;
                q_d   = q_it;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef DIV_RESTORING_EN
                    quot_d  = q_it;
                    rem_d   = a_it[N-1:0];
                    state_d = S_DONE;
`else
                    state_d = S_FIX;
`endif
                end
            end
`ifndef DIV_RESTORING_EN
            S_FIX: begin
                a_d     = a_fix;
                quot_d  = q_q;
                rem_d   = a_fix[N-1:0];
                state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        rdy_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            rdy_q   <= rdy_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign ready     = rdy_q;

endmodule

// File: tb/tb_div_nrda_fsm.sv
// Self-checking bench for div_nrda_fsm: scoreboard of expected quotient/remainder, latency and handshake checks.
module tb_div_nrda_fsm;

    localparam int N = 8;
`ifdef DIV_RESTORING_EN
    localparam int LAT = N;
`else
    localparam int LAT = N + 1;
`endif
    localparam int GAP = LAT + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         ready;

    div_nrda_fsm #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] last_q = '0;
    logic [N-1:0] last_r = '0;

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Caller guarantees the DUT is in IDLE, sampled #1 after an edge.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit mutate);
        exp_t e;
        int   lat;
        bit   seen;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk); #1;
        start = 1'b0;
        if (mutate) begin
            dividend = N'($urandom);
            divisor  = N'($urandom);
        end
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                seen = 1'b1;
                lat  = k;
            end else if (k == 2) begin
                total++;
                if (quotient !== last_q || remainder !== last_r) begin
                    bad++;
                    $display("FAIL hold %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d", a, b, quotient, remainder, last_q, last_r);
                end
            end
        end
        e = sb.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL timeout %0d/%0d: ready not seen in 40 cycles", a, b);
            return;
        end
        if (lat !== LAT) begin
            bad++;
            $display("FAIL latency %0d/%0d: got %0d want %0d", a, b, lat, LAT);
        end
        total++;
        if (quotient !== e.q) begin
            bad++;
            $display("FAIL quotient %0d/%0d: got %0d want %0d", a, b, quotient, e.q);
        end
        total++;
        if (remainder !== e.r) begin
            bad++;
            $display("FAIL remainder %0d/%0d: got %0d want %0d", a, b, remainder, e.r);
        end
        last_q = e.q;
        last_r = e.r;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_width %0d/%0d: got %b want 0", a, b, ready);
        end
    endtask

    task automatic test_reset;
        #12;
        total++;
        if (ready !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b q=%0d r=%0d want 0 0 0", ready, quotient, remainder);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_ready: got %b want 0", ready);
        end
    endtask

    task automatic test_basic;
        run_op(8'd11, 8'd3, 1'b0);
        run_op(8'd115, 8'd7, 1'b0);
        run_op(8'd113, 8'd19, 1'b0);
        run_op(8'd200, 8'd13, 1'b0);
    endtask

    task automatic test_boundaries;
        run_op(8'd255, 8'd1, 1'b0);
        run_op(8'd5, 8'd200, 1'b0);
        run_op(8'd0, 8'd7, 1'b0);
        run_op(8'd255, 8'd255, 1'b0);
    endtask

    task automatic test_div_zero;
        run_op(8'd200, 8'd0, 1'b0);
    endtask

    task automatic test_operand_change;
        run_op(8'd115, 8'd7, 1'b1);
        run_op(8'd113, 8'd19, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] pa [3];
        logic [N-1:0] pb [3];
        exp_t         e;
        int           prev;
        bit           seen;
        pa[0] = 8'd200; pb[0] = 8'd13;
        pa[1] = 8'd115; pb[1] = 8'd7;
        pa[2] = 8'd255; pb[2] = 8'd255;
        prev     = -1;
        dividend = pa[0];
        divisor  = pb[0];
        sb.push_back(model(pa[0], pb[0]));
        start    = 1'b1;
        for (int p = 0; p < 3; p++) begin
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                @(posedge clk); #1;
                if (ready) seen = 1'b1;
            end
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL b2b_timeout pulse %0d: ready not seen", p);
                break;
            end
            e = sb.pop_front();
            if (quotient !== e.q || remainder !== e.r) begin
                bad++;
                $display("FAIL b2b_result pulse %0d: got q=%0d r=%0d want q=%0d r=%0d", p, quotient, remainder, e.q, e.r);
            end
            last_q = e.q;
            last_r = e.r;
            if (prev >= 0) begin
                total++;
                if (cyc - prev !== GAP) begin
                    bad++;
                    $display("FAIL b2b_gap pulse %0d: got %0d want %0d", p, cyc - prev, GAP);
                end
            end
            prev = cyc;
            if (p < 2) begin
                dividend = pa[p+1];
                divisor  = pb[p+1];
                sb.push_back(model(pa[p+1], pb[p+1]));
            end
        end
        start = 1'b0;
        sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun;
        dividend = 8'd200;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            bad++;
            $display("FAIL midrun_reset: got rdy=%b q=%0d r=%0d want 0 0 0", ready, quotient, remainder);
        end
        last_q = '0;
        last_r = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_op(8'd115, 8'd7, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_operand_change();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_nrda_fsm.md
# div_nrda_fsm

Sequential unsigned integer divider computing `quotient = dividend / divisor` and `remainder = dividend % divisor` for N-bit operands. It retires one quotient bit per clock, with `start`/`ready` handshaking. The default build uses the non-restoring algorithm (NRDA). A compile-time option builds the restoring algorithm (RDA) instead, so both variants can be compared in the same datapath slot.

## Interface
- `N`, default 8: operand and result width in bits (N ≥ 2).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request pulse; sampled only in IDLE.
- `dividend`  in  N: unsigned dividend; latched when `start` is accepted.
- `divisor`  in  N: unsigned divisor; latched when `start` is accepted.
- `quotient`  out  N: registered result; held until the next completion.
- `remainder`  out  N: registered result; held until the next completion.
- `ready`  out  1: high for exactly one cycle, in DONE, when the results are valid.

## Operation
- States:
  - IDLE → RUN when `start`=1.
  - RUN → FIX after the N-th iteration (NRDA), or → DONE (RDA).
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- Datapath registers:
  - A: N+1-bit two's-complement partial remainder.
  - Q: N-bit dividend/quotient register.
  - M: N+1-bit zero-extended divisor.
  - Iteration counter of ceil(log2(N+1)) bits.
- Load (IDLE and `start`): A=0, Q=`dividend`, M={0,`divisor`}, count=N.
- NRDA iteration:
  - Let s = sign of A before the shift.
  - {A,Q} shifted left by 1.
  - If s=1, A=A+M; otherwise A=A−M.
  - Q[0] = ~sign(new A).
  - count decrements.
- NRDA FIX: if A is negative, A=A+M. Remainder = A[N-1:0], quotient = Q.
- RDA iteration:
  - {A,Q} shifted left by 1; T=A−M.
  - If T is negative, keep the shifted A and set Q[0]=0.
  - Otherwise A=T and Q[0]=1.
  - Restore is combinational within the same cycle.
- All arithmetic is modulo 2^(N+1) on A. Results are truncated to N bits; no overflow is possible.
- Divide by zero: no special case and no error flag. Both variants naturally yield `quotient` = all ones and `remainder` = `dividend`; this is the required result.
- `start` in RUN, FIX or DONE is ignored; there is no queuing. Operand changes after acceptance are ignored.
- `quotient` and `remainder` are written only on entry to DONE. They keep their previous values during a computation.

## Timing
- Edge 0: `start` sampled high in IDLE, operands loaded, state becomes RUN.
- Edges 1..N: one iteration per edge.
- NRDA: edge N enters FIX; edge N+1 performs the correction, writes the outputs and enters DONE. `ready` is high for the single cycle after edge N+1 (N=8: 9 edges after acceptance).
- RDA: edge N writes the outputs and enters DONE. `ready` is high for the cycle after edge N (N=8: 8 edges).
- `ready` = (state == DONE), taken from the state register with no combinational path from inputs.
- Earliest next acceptance: the edge after DONE, i.e. in IDLE. Back-to-back throughput is N+3 cycles (NRDA) or N+2 cycles (RDA).
- Reset state (also on assertion mid-operation, immediately and asynchronously):
  - state=IDLE.
  - `quotient`=0, `remainder`=0, `ready`=0.
  - A, Q, M and the counter cleared.
  - Any computation in flight is abandoned.

## Configuration
- `DIV_RESTORING_EN`:
  - Defined: restoring algorithm; the FIX state is not built; latency is N edges.
  - Undefined (default): non-restoring algorithm with the FIX state; latency is N+1 edges.
- Interface, reset behaviour and results are identical in both builds.

## Test plan
- 11 / 3 → Q=3, R=2. `ready` for exactly one cycle, 9 edges after acceptance (NRDA) or 8 (RDA).
- 115 / 7 → Q=16, R=3. 113 / 19 → Q=5, R=18. 200 / 13 → Q=15, R=5. Both builds must match.
- Boundaries:
  - 255 / 1 → Q=255, R=0.
  - 5 / 200 → Q=0, R=5.
  - 0 / 7 → Q=0, R=0.
  - 255 / 255 → Q=1, R=0.
- 200 / 0 → Q=255, R=200, with no hang.
- Back-to-back:
  - `start` held high throughout: successive acceptances occur N+3 (NRDA) or N+2 (RDA) cycles apart.
  - Operands changed mid-run: result matches the latched operands.
  - Outputs hold their values between runs.
- `reset` asserted low at iteration 4: `ready`, `quotient` and `remainder` go to 0 at once. A fresh 115/7 after release → Q=16, R=3.
